ofdm_frame_sequencer: RTL and testbench

Sequences one OFDM frame as a stream of subcarrier slots feeding the IFFT input mux. Each slot is tagged PREAMBLE, PILOT or DATA, with subcarrier and symbol indices, so the mux selects the preamble ROM, the pilot register or the QAM output. The sequencer sits between the register controller, which supplies the config words, and the QAM/pilot/IFFT datapath, and throttles on downstream back-pressure.

---
 rtl/ofdm_pkg.sv | 22 ++
 rtl/ofdm_pilot_marker.sv | 30 +++
 rtl/ofdm_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ofdm_frame_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared encodings for the OFDM frame sequencer and the pilot marker.
// Slot-type values are what the IFFT input mux decodes.
package ofdm_pkg;

  localparam int FFT_LOG2_MIN = 3;
  localparam int FFT_LOG2_MAX = 13;

  typedef enum logic [1:0] {
    SLOT_NONE = 2'b00,
    SLOT_PRE  = 2'b01,
    SLOT_PIL  = 2'b10,
    SLOT_DATA = 2'b11
  } slot_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_FIN
  } state_e;

endpackage

// File: rtl/ofdm_pilot_marker.sv
// Pilot position tracker: one step per generated data slot, reports whether
// the slot being generated is a pilot. Shared with the receive-side extractor.
module ofdm_pilot_marker #(
  parameter int IDX_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             sym_start,
  input  logic [IDX_W-1:0] offset,
  input  logic [IDX_W-1:0] spacing,
  output logic             is_pilot
);

  logic [IDX_W-1:0] pil_cnt;
  logic [IDX_W-1:0] cur_cnt;

  // At a symbol start the offset takes the place of the running count.
  assign cur_cnt  = sym_start ? offset : pil_cnt;
  assign is_pilot = (cur_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pil_cnt <= '0;
    end else if (step) begin
      pil_cnt <= is_pilot ? spacing - 1'b1 : cur_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// Emits one OFDM frame as tagged subcarrier slots (preamble, pilot, data)
// over a valid/ready handshake towards the IFFT input mux.
module ofdm_frame_sequencer
  import ofdm_pkg::*;
#(
  parameter int SYM_W = 16,
  parameter int IDX_W = 13,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       cfg_fft_log2,
  input  logic [PRE_W-1:0] cfg_num_pre,
  input  logic [SYM_W-1:0] cfg_num_sym,
  input  logic [IDX_W-1:0] cfg_pil_offset,
  input  logic [IDX_W-1:0] cfg_pil_spacing,
  output logic             slot_valid,
  input  logic             slot_ready,
  output logic [1:0]       slot_type,
  output logic [IDX_W-1:0] slot_idx,
  output logic [SYM_W-1:0] sym_idx,
  output logic             sos,
  output logic             eos,
  output logic             eof,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  function automatic logic cfg_ok(input logic [3:0] lg, input logic [SYM_W-1:0] ns,
                                  input logic [IDX_W-1:0] sp);
    return (lg >= 4'(FFT_LOG2_MIN)) && (lg <= 4'(FFT_LOG2_MAX)) && (ns != '0) && (sp != '0);
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input logic [3:0] lg);
    logic [IDX_W:0] n;
    n = (IDX_W+1)'(1) << lg;
    return IDX_W'(n - 1'b1);
  endfunction

  state_e           state;
  logic [IDX_W-1:0] n_last_l, off_l, sp_l;
  logic [PRE_W-1:0] num_pre_l;
  logic [SYM_W-1:0] num_sym_l, dsym_cnt;

  logic             start_ok, xfer, adv;
  logic [IDX_W-1:0] nxt_idx;
  logic [SYM_W-1:0] nxt_sym, nxt_dsym;
  logic             pre_end, nxt_data, nxt_eof;
  logic [IDX_W-1:0] mk_offset, mk_spacing;
  logic             mk_sym_start, mk_step, is_pilot;

  assign start_ok = (state == ST_IDLE) && start &&
                    cfg_ok(cfg_fft_log2, cfg_num_sym, cfg_pil_spacing);
  assign xfer     = slot_valid && slot_ready;
  assign adv      = ((state == ST_PRE) || (state == ST_DATA)) && xfer && !eof && !abort;

  // Next-slot geometry, derived from the slot currently on the outputs.
  assign nxt_idx  = eos ? '0 : slot_idx + 1'b1;
  assign nxt_sym  = eos ? sym_idx + 1'b1 : sym_idx;
  assign pre_end  = (state == ST_PRE) && eos && (sym_idx == SYM_W'(num_pre_l) - 1'b1);
  assign nxt_data = (state == ST_DATA) || pre_end;
  assign nxt_dsym = ((state == ST_DATA) && eos) ? dsym_cnt + 1'b1 : dsym_cnt;
  assign nxt_eof  = nxt_data && (nxt_idx == n_last_l) && (nxt_dsym == num_sym_l - 1'b1);

  // The first slot is built straight from the cfg inputs, before they are latched.
  assign mk_offset    = (state == ST_IDLE) ? cfg_pil_offset  : off_l;
  assign mk_spacing   = (state == ST_IDLE) ? cfg_pil_spacing : sp_l;
  assign mk_sym_start = (state == ST_IDLE) ? 1'b1 : (nxt_idx == '0);
  assign mk_step      = (start_ok && (cfg_num_pre == '0)) || (adv && nxt_data);

  ofdm_pilot_marker #(.IDX_W(IDX_W)) u_pilot_marker (
    .clk       (clk),
    .rst       (rst),
    .step      (mk_step),
    .sym_start (mk_sym_start),
    .offset    (mk_offset),
    .spacing   (mk_spacing),
    .is_pilot  (is_pilot)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      slot_valid <= 1'b0;
      slot_type  <= SLOT_NONE;
      slot_idx   <= '0;
      sym_idx    <= '0;
      dsym_cnt   <= '0;
      sos        <= 1'b0;
      eos        <= 1'b0;
      eof        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      n_last_l   <= '0;
      off_l      <= '0;
      sp_l       <= '0;
      num_pre_l  <= '0;
      num_sym_l  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !start_ok) begin
            cfg_err <= 1'b1;
          end else if (start_ok) begin
            cfg_err    <= 1'b0;
            busy       <= 1'b1;
            n_last_l   <= last_idx(cfg_fft_log2);
            off_l      <= cfg_pil_offset;
            sp_l       <= cfg_pil_spacing;
            num_pre_l  <= cfg_num_pre;
            num_sym_l  <= cfg_num_sym;
            slot_valid <= 1'b1;
            slot_idx   <= '0;
            sym_idx    <= '0;
            dsym_cnt   <= '0;
            sos        <= 1'b1;
            eos        <= 1'b0;
            eof        <= 1'b0;
            if (cfg_num_pre != '0) begin
              state     <= ST_PRE;
              slot_type <= SLOT_PRE;
            end else begin
              state     <= ST_DATA;
              slot_type <= is_pilot ? SLOT_PIL : SLOT_DATA;
            end
          end
        end
        ST_PRE, ST_DATA: begin
          if (abort) begin
            slot_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (xfer && eof) begin
            slot_valid <= 1'b0;
            state      <= ST_FIN;
          end else if (adv) begin
            slot_idx  <= nxt_idx;
            sym_idx   <= nxt_sym;
            dsym_cnt  <= nxt_dsym;
            sos       <= (nxt_idx == '0);
            eos       <= (nxt_idx == n_last_l);
            eof       <= nxt_eof;
            state     <= nxt_data ? ST_DATA : ST_PRE;
            slot_type <= !nxt_data ? SLOT_PRE : (is_pilot ? SLOT_PIL : SLOT_DATA);
          end
        end
        ST_FIN: begin
          done  <= !abort;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Directed bench for ofdm_frame_sequencer: expected slots are queued at
// stimulus time and a negedge monitor compares every presented slot.
module tb_ofdm_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  cfg_fft_log2 = '0;
  logic [3:0]  cfg_num_pre = '0;
  logic [15:0] cfg_num_sym = '0;
  logic [12:0] cfg_pil_offset = '0;
  logic [12:0] cfg_pil_spacing = '0;
  logic        slot_valid;
  logic        slot_ready = 1'b0;
  logic [1:0]  slot_type;
  logic [12:0] slot_idx;
  logic [15:0] sym_idx;
  logic        sos, eos, eof, busy, done, cfg_err;

  typedef struct packed {
    logic [1:0]  t;
    logic [12:0] idx;
    logic [15:0] sym;
    logic        sos;
    logic        eos;
    logic        eof;
  } slot_t;

  slot_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    xfer_cnt = 0;
  bit    rand_mode = 1'b0;
  bit    rdy_force = 1'b1;
  bit    eof_d1 = 1'b0, eof_d2 = 1'b0, exp_done;

  ofdm_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_fft_log2(cfg_fft_log2), .cfg_num_pre(cfg_num_pre), .cfg_num_sym(cfg_num_sym),
    .cfg_pil_offset(cfg_pil_offset), .cfg_pil_spacing(cfg_pil_spacing),
    .slot_valid(slot_valid), .slot_ready(slot_ready), .slot_type(slot_type),
    .slot_idx(slot_idx), .sym_idx(sym_idx), .sos(sos), .eos(eos), .eof(eof),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    slot_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: every presented slot must match the queue head; pop on transfer.
  always @(negedge clk) begin
    slot_t e;
    if (slot_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL extra_slot got type %0d idx %0d sym %0d want none", slot_type, slot_idx, sym_idx);
      end else begin
        e = q[0];
        if ({slot_type, slot_idx, sym_idx, sos, eos, eof} !== e) begin
          errors++;
          $display("FAIL slot%0d got t%0d i%0d s%0d sos%0b eos%0b eof%0b want t%0d i%0d s%0d sos%0b eos%0b eof%0b",
                   xfer_cnt, slot_type, slot_idx, sym_idx, sos, eos, eof,
                   e.t, e.idx, e.sym, e.sos, e.eos, e.eof);
        end
        if (slot_ready) begin
          void'(q.pop_front());
          xfer_cnt++;
        end
      end
    end
    exp_done = eof_d2;
    eof_d2   = eof_d1;
    eof_d1   = slot_valid && slot_ready && eof;
    if (done || exp_done) begin
      checks++;
      if (done !== exp_done || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse got done %0b busy %0b want done %0b busy 0", done, busy, exp_done);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_frame(input int lg, input int npre, input int nsym, input int off, input int sp);
    int n;
    slot_t e;
    n = 1 << lg;
    for (int s = 0; s < npre + nsym; s++) begin
      for (int i = 0; i < n; i++) begin
        if (s < npre)                              e.t = 2'b01;
        else if (i >= off && ((i - off) % sp) == 0) e.t = 2'b10;
        else                                        e.t = 2'b11;
        e.idx = 13'(i);
        e.sym = 16'(s);
        e.sos = (i == 0);
        e.eos = (i == n - 1);
        e.eof = (s == npre + nsym - 1) && (i == n - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input int lg, input int npre, input int nsym, input int off, input int sp);
    @(posedge clk);
    #1;
    cfg_fft_log2    = 4'(lg);
    cfg_num_pre     = 4'(npre);
    cfg_num_sym     = 16'(nsym);
    cfg_pil_offset  = 13'(off);
    cfg_pil_spacing = 13'(sp);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy && !slot_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'({ok, q.size() == 0}), 64'd3);
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({slot_valid, busy, done, cfg_err, sos, eos, eof, slot_type, slot_idx, sym_idx}), 64'd0);
    rst = 1'b1;

    // Nominal frame, ready tied high.
    push_frame(3, 1, 2, 1, 4);
    do_start(3, 1, 2, 1, 4);
    @(negedge clk);
    chk("busy_after_start", 64'({busy, slot_valid}), 64'd3);
    wait_idle("nominal_end", 100);

    // Same frame under random back-pressure.
    rand_mode = 1'b1;
    push_frame(3, 1, 2, 1, 4);
    do_start(3, 1, 2, 1, 4);
    wait_idle("stall_end", 400);
    rand_mode = 1'b0;

    // Illegal configurations, then a legal start clears the error.
    do_start(2, 1, 2, 1, 4);
    @(negedge clk);
    chk("err_log2", 64'({cfg_err, busy, slot_valid}), 64'b100);
    do_start(3, 1, 2, 1, 0);
    @(negedge clk);
    chk("err_spacing", 64'({cfg_err, busy, slot_valid}), 64'b100);
    push_frame(3, 0, 1, 2, 3);
    do_start(3, 0, 1, 2, 3);
    @(negedge clk);
    chk("err_cleared", 64'({cfg_err, busy}), 64'b01);
    wait_idle("legal_end", 100);

    // Pilot edge cases with no preamble.
    push_frame(3, 0, 1, 8, 1);
    do_start(3, 0, 1, 8, 1);
    wait_idle("no_pilot_end", 100);
    push_frame(3, 0, 1, 0, 1);
    do_start(3, 0, 1, 0, 1);
    wait_idle("all_pilot_end", 100);

    // Abort while stalled on slot 10.
    base = xfer_cnt;
    push_frame(3, 1, 2, 1, 4);
    do_start(3, 1, 2, 1, 4);
    repeat (9) @(posedge clk);
    #2 rdy_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({slot_valid, busy, done}), 64'd0);
    chk("abort_xfers", 64'(xfer_cnt - base), 64'd10);
    q.delete();
    rdy_force = 1'b1;
    repeat (3) @(negedge clk);
    push_frame(3, 1, 2, 1, 4);
    do_start(3, 1, 2, 1, 4);
    wait_idle("rerun_end", 100);

    // Asynchronous reset mid-frame, then junk inputs without start.
    push_frame(3, 1, 2, 1, 4);
    do_start(3, 1, 2, 1, 4);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_reset", 64'({slot_valid, busy, done, cfg_err, sos, eos, eof, slot_type, slot_idx, sym_idx}), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    rand_mode = 1'b1;
    cfg_fft_log2 = 4'd4;
    abort = 1'b1;
    repeat (4) @(negedge clk);
    abort = 1'b0;
    chk("idle_after_reset", 64'({slot_valid, busy, done, cfg_err}), 64'd0);
    rand_mode = 1'b0;
    push_frame(3, 0, 1, 1, 4);
    do_start(3, 0, 1, 1, 4);
    wait_idle("post_reset_end", 100);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
